// File: rtl/toi2s_pkg.sv
// Shared types and constants for the amplifier I2C master.
package toi2s_pkg;

  // Quarter-period length that gives roughly 100 kHz SCL from a 27 MHz clock
  localparam int AMP_I2C_CLK_DIV_DEFAULT = 68;

  // One state per bus phase; the read-only phases stay in the type in every build
  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR_W,
    REG,
    DATA,
    RSTART,
    ADDR_R,
    READ,
    MNACK,
    STOP
  } amp_i2c_state_t;

endpackage

// File: rtl/amp_i2c_tick.sv
// Quarter-period prescaler for the amplifier I2C master.
// Emits a one-cycle qtick on the last cycle of each quarter and tracks the
// quarter index q0..q3 within the current bit period.
module amp_i2c_tick
  import toi2s_pkg::*;
#(
  parameter int CLK_DIV = AMP_I2C_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       clear,
  output logic       qtick,
  output logic [1:0] quarter
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] count;

  assign qtick = (count == LAST);

  // Count clk cycles within a quarter and advance the quarter index on wrap
  always_ff @(posedge clk) begin
    if (!resetb || clear) begin
      count   <= '0;
      quarter <= '0;
    end else if (qtick) begin
      count   <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      count   <= count + 8'd1;
    end
  end

endmodule

// File: rtl/amp_i2c_master.sv
// I2C master for single-register writes to the amplifier control port.
// Define AMP_I2C_READ_EN to compile in the repeated-START register read;
// without it a read request completes at once with ack_err set.
module amp_i2c_master
  import toi2s_pkg::*;
#(
  parameter int CLK_DIV = AMP_I2C_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_o,
  output logic       sda_oe,
  input  logic       sda_i
);

  amp_i2c_state_t state;
  logic [3:0]     bit_cnt;
  logic [6:0]     shift;
  logic [6:0]     dev_q;
  logic [7:0]     reg_q;
  logic [7:0]     data_q;
  logic           qtick;
  logic [1:0]     quarter;
  logic           tx_byte;

`ifdef AMP_I2C_READ_EN
  logic           rw_q;
  logic [7:0]     rd_shift;
  logic [7:0]     rd_q;
  assign rd_data = rd_q;
`else
  assign rd_data = '0;
`endif

  // Prescaler sits at q0 count 0 whenever idle so each transaction starts aligned
  amp_i2c_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .resetb  (resetb),
    .clear   (state == IDLE),
    .qtick   (qtick),
    .quarter (quarter)
  );

  assign tx_byte = (state == ADDR_W) || (state == REG) ||
                   (state == DATA) || (state == ADDR_R);

  // Bus sequencer: shift holds the bits still to send after the one on SDA
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      dev_q    <= '0;
      reg_q    <= '0;
      data_q   <= '0;
      scl_o    <= 1'b1;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
`ifdef AMP_I2C_READ_EN
      rw_q     <= 1'b0;
      rd_shift <= '0;
      rd_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          dev_q   <= dev_addr;
          reg_q   <= reg_addr;
          data_q  <= wr_data;
          ack_err <= 1'b0;
`ifdef AMP_I2C_READ_EN
          rw_q     <= rw;
          rd_shift <= '0;
          state    <= START;
          busy     <= 1'b1;
`else
          if (rw) begin
            done    <= 1'b1;
            ack_err <= 1'b1;
          end else begin
            state <= START;
            busy  <= 1'b1;
          end
`endif
        end
      end else if (qtick) begin
        case (quarter)
          2'd0: scl_o <= 1'b1;
          2'd1: begin
            case (state)
              START:   sda_oe <= 1'b1;
              RSTART:  sda_oe <= 1'b1;
              STOP:    sda_oe <= 1'b0;
              default: ;
            endcase
            if (tx_byte && bit_cnt == 4'd8 && sda_i) begin
              ack_err <= 1'b1;
            end
`ifdef AMP_I2C_READ_EN
            if (state == READ) begin
              rd_shift <= {rd_shift[6:0], sda_i};
            end
`endif
          end
          2'd2: begin
            if (state != STOP) begin
              scl_o <= 1'b0;
            end
          end
          default: begin
            case (state)
              START: begin
                state   <= ADDR_W;
                bit_cnt <= '0;
                shift   <= {dev_q[5:0], 1'b0};
                sda_oe  <= ~dev_q[6];
              end
              STOP: begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
`ifdef AMP_I2C_READ_EN
                rd_q  <= rd_shift;
`endif
              end
`ifdef AMP_I2C_READ_EN
              RSTART: begin
                state   <= ADDR_R;
                bit_cnt <= '0;
                shift   <= {dev_q[5:0], 1'b1};
                sda_oe  <= ~dev_q[6];
              end
              READ: begin
                if (bit_cnt < 4'd7) begin
                  bit_cnt <= bit_cnt + 4'd1;
                end else begin
                  state   <= MNACK;
                  bit_cnt <= '0;
                end
              end
              MNACK: begin
                state  <= STOP;
                sda_oe <= 1'b1;
              end
`endif
              default: begin
                if (bit_cnt < 4'd7) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  shift   <= {shift[5:0], 1'b0};
                  sda_oe  <= ~shift[6];
                end else if (bit_cnt == 4'd7) begin
                  bit_cnt <= 4'd8;
                  sda_oe  <= 1'b0;
                end else if (ack_err) begin
                  state  <= STOP;
                  sda_oe <= 1'b1;
                end else begin
                  bit_cnt <= '0;
                  case (state)
                    ADDR_W: begin
                      state  <= REG;
                      shift  <= reg_q[6:0];
                      sda_oe <= ~reg_q[7];
                    end
                    REG: begin
`ifdef AMP_I2C_READ_EN
                      if (rw_q) begin
                        state  <= RSTART;
                        sda_oe <= 1'b0;
                      end else begin
                        state  <= DATA;
                        shift  <= data_q[6:0];
                        sda_oe <= ~data_q[7];
                      end
`else
                      state  <= DATA;
                      shift  <= data_q[6:0];
                      sda_oe <= ~data_q[7];
`endif
                    end
`ifdef AMP_I2C_READ_EN
                    ADDR_R: begin
                      state  <= READ;
                      sda_oe <= 1'b0;
                    end
`endif
                    default: begin
                      state  <= STOP;
                      sda_oe <= 1'b1;
                    end
                  endcase
                end
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule
